uart_frame_parser: RTL and testbench

- Sits directly downstream of the UART byte receiver and consumes its 8-bit data / single-cycle valid byte stream.
- Delineates frames of the form SYNC, LEN, payload[LEN], CHK.
- Buffers the payload and verifies the checksum.
- Releases only good frames to the core on a ready/valid byte stream with last marker; bad frames are discarded and flagged.

---
 rtl/uart_frame_parser.sv | 176 +++++++++++++++++
 tb/tb_uart_frame_parser.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// Frame parser for a UART byte stream: SYNC, LEN, payload[LEN], CHK -> ready/valid payload drain.
// Optional inter-byte idle timeout is enabled with `define UART_FRAME_TIMEOUT_EN.
module uart_frame_parser #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned MAX_LEN   = 16
`ifdef UART_FRAME_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 100000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       overrun,
  output logic [7:0] err_count
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned DEPTH = 1 << IDX_W;

  typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [7:0]         len_q, len_d;
  logic [7:0]         sum_q, sum_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic [7:0]         m_data_d;
  logic               m_valid_d, m_last_d;
  logic               frame_ok_d, frame_err_d, overrun_d;
  logic [7:0]         err_count_d;
  logic               wr_en;
  logic [7:0]         pay_buf [DEPTH];

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] idle_q, idle_d;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    sum_d       = sum_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    m_data_d    = m_data;
    m_valid_d   = m_valid;
    m_last_d    = m_last;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      S_HUNT: begin
        if (in_valid && in_data == SYNC_BYTE) state_d = S_LEN;
      end
      S_LEN: begin
        if (in_valid) begin
          if (in_data == 8'd0 || 32'(in_data) > MAX_LEN) begin
            frame_err_d = 1'b1;
            state_d     = S_HUNT;
          end else begin
            len_d    = in_data;
            sum_d    = in_data;
            wr_idx_d = '0;
            state_d  = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (in_valid) begin
          wr_en = 1'b1;
          sum_d = sum_q + in_data;
          if (8'(wr_idx_q) == len_q - 8'd1) state_d = S_CHK;
          else wr_idx_d = wr_idx_q + IDX_W'(1);
        end
      end
      S_CHK: begin
        if (in_valid) begin
          if (in_data == sum_q) begin
            frame_ok_d = 1'b1;
            rd_idx_d   = '0;
            m_valid_d  = 1'b1;
            m_data_d   = pay_buf[0];
            m_last_d   = (len_q == 8'd1);
            state_d    = S_DRAIN;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_HUNT;
          end
        end
      end
      S_DRAIN: begin
        overrun_d = in_valid;
        if (m_valid && m_ready) begin
          if (m_last) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            state_d   = S_HUNT;
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
            m_data_d = pay_buf[rd_idx_d];
            m_last_d = (8'(rd_idx_d) == len_q - 8'd1);
          end
        end
      end
      default: state_d = S_HUNT;
    endcase

`ifdef UART_FRAME_TIMEOUT_EN
    // Idle counter only advances mid-frame; any byte or state change clears it
    idle_d = '0;
    if ((state_q inside {S_LEN, S_PAYLOAD, S_CHK}) && !in_valid) begin
      if (idle_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        frame_err_d = 1'b1;
        state_d     = S_HUNT;
      end else begin
        idle_d = idle_q + TO_W'(1);
      end
    end
`endif

    err_count_d = err_count;
    if (frame_err_d && err_count != 8'hFF) err_count_d = err_count + 8'd1;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_HUNT;
      len_q     <= '0;
      sum_q     <= '0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      err_count <= '0;
`ifdef UART_FRAME_TIMEOUT_EN
      idle_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      m_data    <= m_data_d;
      m_valid   <= m_valid_d;
      m_last    <= m_last_d;
      frame_ok  <= frame_ok_d;
      frame_err <= frame_err_d;
      overrun   <= overrun_d;
      err_count <= err_count_d;
`ifdef UART_FRAME_TIMEOUT_EN
      idle_q    <= idle_d;
`endif
    end
  end

  // Payload buffer; contents are don't-care until rewritten by the next frame
  always_ff @(posedge clk) begin
    if (wr_en) pay_buf[wr_idx_q] <= in_data;
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: frame vector table plus stall, overrun, saturation and reset sequences.
module tb_uart_frame_parser;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic       frame_ok;
  logic       frame_err;
  logic       overrun;
  logic [7:0] err_count;

  uart_frame_parser #(
    .SYNC_BYTE(8'hA5),
    .MAX_LEN(16)
`ifdef UART_FRAME_TIMEOUT_EN
    , .TIMEOUT_CYCLES(50)
`endif
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .frame_ok(frame_ok), .frame_err(frame_err), .overrun(overrun), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int   n;      // bytes in this vector
    int   poff;   // offset of first payload byte
    logic ok;     // frame_ok pulses expected
    int   nerr;   // frame_err pulses expected
    int   nbeat;  // output beats expected
    int   ecnt;   // err_count expected afterwards
  } vec_t;

  localparam int NVEC = 7;
  vec_t       vecs [NVEC];
  int         vstart [NVEC];
  logic [7:0] pool [$];

  int total = 0;
  int bad   = 0;

  // Output monitor, sampled on the falling edge
  int         ok_cnt = 0, err_cnt = 0, ovr_cnt = 0, both_cnt = 0;
  logic [8:0] beats [$];
  always @(negedge clk) begin
    if (frame_ok) ok_cnt++;
    if (frame_err) err_cnt++;
    if (overrun) ovr_cnt++;
    if (frame_ok && frame_err) both_cnt++;
    if (m_valid && m_ready) beats.push_back({m_last, m_data});
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1
  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while (m_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_drain_bound"}, int'(cyc < 40), 1);
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input int k, input int ecnt);
    int    b0, ok0, er0, nb;
    string nm;
    nm  = $sformatf("v%0d", k);
    b0  = beats.size();
    ok0 = ok_cnt;
    er0 = err_cnt;
    for (int i = 0; i < vecs[k].n; i++) send(pool[vstart[k] + i]);
    check({nm, "_first_beat"}, int'(m_valid), int'(vecs[k].ok));
    wait_drain(nm);
    check({nm, "_ok_pulses"}, ok_cnt - ok0, int'(vecs[k].ok));
    check({nm, "_err_pulses"}, err_cnt - er0, vecs[k].nerr);
    nb = beats.size() - b0;
    check({nm, "_beats"}, nb, vecs[k].nbeat);
    for (int i = 0; i < vecs[k].nbeat && i < nb; i++) begin
      check($sformatf("%s_beat%0d", nm, i), int'(beats[b0 + i]),
            int'({(i == vecs[k].nbeat - 1), pool[vstart[k] + vecs[k].poff + i]}));
    end
    check({nm, "_err_count"}, int'(err_count), ecnt);
  endtask

  initial begin
    int b0, o0, e0, unstable;

    pool = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69,
            8'hA5, 8'h02, 8'h10, 8'h20, 8'h00,
            8'hA5, 8'h01, 8'h7F, 8'h80,
            8'hA5, 8'h00,
            8'hA5, 8'h11,
            8'h00, 8'hFF, 8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h4C,
            8'hA5, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
            8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h98};
    vecs[0] = '{6,  2, 1'b1, 0, 3,  0};  // good, 3 beats
    vecs[1] = '{5,  2, 1'b0, 1, 0,  1};  // bad checksum
    vecs[2] = '{4,  2, 1'b1, 0, 1,  1};  // single-byte payload
    vecs[3] = '{2,  2, 1'b0, 1, 0,  2};  // LEN = 0
    vecs[4] = '{2,  2, 1'b0, 1, 0,  3};  // LEN = MAX_LEN+1
    vecs[5] = '{7,  4, 1'b1, 0, 2,  3};  // noise, then SYNC values inside payload
    vecs[6] = '{19, 2, 1'b1, 0, 16, 3};  // LEN = MAX_LEN
    vstart[0] = 0;
    for (int k = 1; k < NVEC; k++) vstart[k] = vstart[k-1] + vecs[k-1].n;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_last", int'(m_last), 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_frame_ok", int'(frame_ok), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_err_count", int'(err_count), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < NVEC; k++) run_vec(k, vecs[k].ecnt);

    // Backpressure: 10-cycle stall with two bytes injected mid-drain
    m_ready = 1'b0;
    b0 = beats.size();
    o0 = ovr_cnt;
    send(8'hA5); send(8'h04); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h0E);
    check("stall_valid", int'(m_valid), 1);
    check("stall_data0", int'(m_data), 8'h01);
    unstable = 0;
    for (int c = 0; c < 10; c++) begin
      in_data  = 8'h5A;
      in_valid = (c == 2 || c == 6);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (m_data !== 8'h01 || m_last !== 1'b0 || m_valid !== 1'b1) unstable++;
    end
    check("stall_unstable_cycles", unstable, 0);
    m_ready = 1'b1;
    wait_drain("stall");
    check("stall_overruns", ovr_cnt - o0, 2);
    check("stall_beats", beats.size() - b0, 4);
    for (int i = 0; i < 4 && b0 + i < beats.size(); i++)
      check($sformatf("stall_beat%0d", i), int'(beats[b0 + i]), int'({(i == 3), 8'(i + 1)}));

    // Byte landing in the drain exit cycle is dropped, even a SYNC value
    o0 = ovr_cnt;
    send(8'hA5); send(8'h01); send(8'h7F); send(8'h80);
    send(8'hA5);
    run_vec(0, 3);
    check("exit_overrun", ovr_cnt - o0, 1);

`ifdef UART_FRAME_TIMEOUT_EN
    e0 = err_cnt;
    send(8'hA5); send(8'h04); send(8'h01);
    repeat (60) @(posedge clk);
    #1;
    check("timeout_err_pulse", err_cnt - e0, 1);
    check("timeout_err_count", int'(err_count), 4);
    run_vec(0, 4);
`endif

    // Saturation of the error counter
    e0 = err_cnt;
    for (int f = 0; f < 300; f++) begin
      send(8'hA5); send(8'h01); send(8'h00); send(8'h00);
    end
    @(posedge clk); #1;
    check("sat_err_pulses", err_cnt - e0, 300);
    check("sat_err_count", int'(err_count), 255);

    // Reset mid-payload, then a clean frame
    send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_err_count", int'(err_count), 0);
    check("midrst_m_valid", int'(m_valid), 0);
    check("midrst_pulses", int'({frame_ok, frame_err, overrun, m_last}), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_vec(0, 0);

    check("ok_err_exclusive", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
